fp_rshift_seq: RTL
==================

Name: fp_rshift_seq

Overview:
Sequential floating-point right-shift unit: computes a / 2^shamt on IEEE-754 single-precision operands, one binary step per clock. It is the divide-by-two counterpart to the FPU's combinational multiply-by-two (left-shift, opcode 7) operation. It handles the normal-to-subnormal transition, truncation loss and underflow, and returns results through a valid/ready handshake to the FPU result mux.

Parameters:
- OPCODE, 4'd8, operation code this unit accepts.
- SHW, 5, shift-amount width; maximum shift is 2^SHW-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- a  in  32  operand in IEEE-754 single format {sign, exp[7:0], mant[22:0]}.
- operation  in  4  FPU opcode.
- shamt  in  SHW  number of divide-by-2 steps.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- rshift_out  out  32  result, registered.
- Underflow  out  1  result is tiny and inexact.
- Inexact  out  1  at least one nonzero bit was shifted out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rshift_out=0, out_valid=0, Underflow=0, Inexact=0.
  - in_ready=1 as soon as rst_n is released.
  - Reset mid-operation aborts the request; no result is produced.
- Accept: transfer = in_valid & in_ready & (operation==OPCODE).
  - Any other opcode is ignored: no transfer, state unchanged.
  - On transfer, latch a into the working register, shamt into the counter cnt, and clear the internal sticky bit. Next state is SHIFT.
- States:
  - IDLE -> SHIFT on transfer.
  - SHIFT: each edge, if cnt==0 go to DONE. Otherwise apply one step and decrement cnt.
  - DONE: out_valid=1. On out_valid & out_ready, go to IDLE.
  - in_ready=0 in SHIFT and DONE.
- Latency: out_valid rises exactly shamt+1 edges after the accept edge, for every input class (fixed latency). shamt=0 therefore gives a pass-through in 1 edge.
- Backpressure: while in DONE with out_ready=0, rshift_out, Underflow and Inexact hold stable.
- One step (sign is never changed):
  - exp==8'hFF (Inf/NaN): hold the value unchanged.
  - exp>=2: exp=exp-1; mant unchanged; exact.
  - exp==1: exp=0; mant={1'b1, mant[22:1]}; sticky |= mant[0].
  - exp==0 (subnormal or zero): mant=mant>>1; sticky |= mant[0]. A zero stays zero, with sign preserved.
- Rounding: truncation toward zero only.
- Flags, registered on entry to DONE:
  - Inexact=sticky.
  - Underflow = sticky & (result exp==0).
  - Inf/NaN/zero inputs and exact subnormal results give Underflow=0.
- Out-of-range shifts: shifting a nonzero finite value until it reaches zero yields signed zero with Inexact=1 and Underflow=1.
- Simultaneous events: out_ready handshake and a new in_valid in the same cycle. The new request is not accepted that cycle (in_ready=0 in DONE). It is accepted the cycle after the return to IDLE.

Decomposition:
- Shared package fpu_pkg holds:
  - OP_LSHIFT=4'd7 and OP_RSHIFT=4'd8.
  - EXP_W=8, MANT_W=23, EXP_SPECIAL=8'hFF.
  - The state enum {IDLE, SHIFT, DONE}.
- One sub-module, fp_rshift_step: purely combinational single step. Inputs are {sign, exp, mant} and sticky_in; outputs are {sign, exp, mant} and sticky_out.
- fp_rshift_seq itself contains the FSM, cnt, the working register and the handshake.

Test Plan:
1. a=0x40000000 (2.0), shamt=1 -> rshift_out=0x3F800000; out_valid 2 edges after accept; Underflow=0, Inexact=0.
2. Normal-to-subnormal boundary:
   - a=0x00800001, shamt=1 -> 0x00400000, Inexact=1, Underflow=1.
   - a=0x00800000, shamt=1 -> 0x00400000, Inexact=0, Underflow=0.
3. a=0x80800000, shamt=24 -> 0x80000000 (signed zero), Inexact=1, Underflow=1; out_valid exactly 25 edges after accept.
4. Specials:
   - a=0x7F800000, shamt=5 -> 0x7F800000, flags 0, latency 6.
   - a=0x7FC00001, shamt=3 -> 0x7FC00001.
   - a=0x00000000, shamt=0 -> 0x00000000, latency 1.
5. Backpressure: hold out_ready=0 for 3 cycles -> out_valid and data stable, in_ready=0, a second in_valid not accepted. Then out_ready=1 -> IDLE, and the second request is accepted on the next edge.
6. Control:
   - in_valid with operation=4'd7 -> no accept; in_ready stays 1 and out_valid never rises.
   - rst_n pulsed low mid-SHIFT -> all outputs 0 immediately, IDLE, and no result is produced afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// +--------------------------------------------------------------------+
// | fpu_pkg : shared FPU opcodes, single-precision field sizes, states |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;
  localparam logic [3:0] OP_LSHIFT   = 4'd7;
  localparam logic [3:0] OP_RSHIFT   = 4'd8;
  localparam int         EXP_W       = 8;
  localparam int         MANT_W      = 23;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/fp_rshift_step.sv
// +--------------------------------------------------------------------+
// | fp_rshift_step : one combinational divide-by-two step with sticky  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fp_rshift_step
  import fpu_pkg::*;
(
  input  fp32_t val_in,
  input  logic  sticky_in,
  output fp32_t val_out,
  output logic  sticky_out
);

  always_comb begin
    val_out    = val_in;
    sticky_out = sticky_in;
    if (val_in.exp == EXP_SPECIAL) begin
      val_out = val_in;
    end else if (val_in.exp >= 8'd2) begin
      val_out.exp = val_in.exp - 8'd1;
    end else if (val_in.exp == 8'd1) begin
      // hidden bit becomes the top mantissa bit of the subnormal
      val_out.exp  = '0;
      val_out.mant = {1'b1, val_in.mant[MANT_W-1:1]};
      sticky_out   = sticky_in | val_in.mant[0];
    end else begin
      val_out.mant = val_in.mant >> 1;
      sticky_out   = sticky_in | val_in.mant[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_rshift_seq.sv
// +--------------------------------------------------------------------+
// | fp_rshift_seq : sequential a / 2^shamt, one step per clock         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fp_rshift_seq
  import fpu_pkg::*;
#(
  parameter logic [3:0] OPCODE = OP_RSHIFT,
  parameter int         SHW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    a,
  input  logic [3:0]     operation,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    rshift_out,
  output logic           Underflow,
  output logic           Inexact
);

  state_t         state;
  state_t         next_state;
  fp32_t          work;
  fp32_t          step_val;
  logic           sticky;
  logic           step_sticky;
  logic [SHW-1:0] cnt;
  logic           transfer;
  logic           cnt_zero;

  assign transfer = in_valid & in_ready & (operation == OPCODE);
  assign cnt_zero = (cnt == '0);

  fp_rshift_step u_step (
    .val_in     (work),
    .sticky_in  (sticky),
    .val_out    (step_val),
    .sticky_out (step_sticky)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (transfer) next_state = SHIFT;
      SHIFT:   if (cnt_zero) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready is masked by rst_n so every output reads zero while reset is held
  always_comb begin
    in_ready  = (state == IDLE) & rst_n;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      sticky     <= 1'b0;
      cnt        <= '0;
      rshift_out <= '0;
      Underflow  <= 1'b0;
      Inexact    <= 1'b0;
    end else begin
      if (state == IDLE && transfer) begin
        work   <= a;
        cnt    <= shamt;
        sticky <= 1'b0;
      end else if (state == SHIFT) begin
        if (cnt_zero) begin
          rshift_out <= work;
          Inexact    <= sticky;
          Underflow  <= sticky & (work.exp == '0);
        end else begin
          work   <= step_val;
          sticky <= step_sticky;
          cnt    <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
